// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, byte-addressed, little-endian
// 32-bit memory between the fetch port (IF) and the load/store port (D).
// Only one access is in flight at a time. Sub-word stores are done as a
// read-modify-write because the memory only writes whole words. Sub-word
// loads are extracted and zero-extended. Misaligned accesses and the illegal
// size are answered with an error and never touch memory.
module mem_port_arbiter #(
   parameter bit FIXED_PRI = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_read_write,
   input  logic [31:0] mem_data_out
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      RMW_RD,
      RMW_WR,
      ACK
   } state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   state_t      state;
   state_t      next_state;

   logic        owner;
   logic        last_grant;
   logic [31:0] acc_addr;
   logic [1:0]  acc_size;
   logic [31:0] acc_wdata;
   logic [31:0] merge;

   logic        if_want;
   logic        d_want;
   logic        grant_if;
   logic        grant_d;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_we;
   logic        req_err;

   logic [31:0] aligned_addr;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_data;
   logic [31:0] merge_word;

   // Arbitration: an acked requester sits out, D wins ties under fixed priority, otherwise the one not served last wins.
   always_comb begin
      if_want  = if_req & ~if_ack;
      d_want   = d_req & ~d_ack;
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (d_want && (!if_want || FIXED_PRI || (last_grant == OWN_IF))) begin
         grant_d = 1'b1;
      end else if (if_want) begin
         grant_if = 1'b1;
      end
   end

   // Decode of the winning request: fetches are always aligned word reads, so only their low address bits can fault.
   always_comb begin
      req_addr = grant_d ? d_addr : if_addr;
      req_size = grant_d ? d_size : SIZE_WORD;
      req_we   = grant_d & d_we;
      case (req_size)
         SIZE_BYTE: req_err = 1'b0;
         SIZE_HALF: req_err = req_addr[0];
         SIZE_WORD: req_err = (req_addr[1:0] != 2'b00);
         default:   req_err = 1'b1;
      endcase
   end

   // Load data extraction: pick the addressed byte or half of the memory word and zero-extend it.
   always_comb begin
      case (acc_addr[1:0])
         2'b00:   sel_byte = mem_data_out[7:0];
         2'b01:   sel_byte = mem_data_out[15:8];
         2'b10:   sel_byte = mem_data_out[23:16];
         default: sel_byte = mem_data_out[31:24];
      endcase
      sel_half = acc_addr[1] ? mem_data_out[31:16] : mem_data_out[15:0];
      case (acc_size)
         SIZE_BYTE: load_data = {24'h0, sel_byte};
         SIZE_HALF: load_data = {16'h0, sel_half};
         default:   load_data = mem_data_out;
      endcase
   end

   // Read-modify-write merge: replace only the addressed byte lane(s) of the word just read.
   always_comb begin
      merge_word = mem_data_out;
      if (acc_size == SIZE_BYTE) begin
         case (acc_addr[1:0])
            2'b00:   merge_word[7:0]   = acc_wdata[7:0];
            2'b01:   merge_word[15:8]  = acc_wdata[7:0];
            2'b10:   merge_word[23:16] = acc_wdata[7:0];
            default: merge_word[31:24] = acc_wdata[7:0];
         endcase
      end else if (acc_addr[1]) begin
         merge_word[31:16] = acc_wdata[15:0];
      end else begin
         merge_word[15:0] = acc_wdata[15:0];
      end
   end

   // Next-state and memory-side outputs; the write strobe is gated by reset so no write lands on a reset edge.
   always_comb begin
      next_state     = state;
      aligned_addr   = {acc_addr[31:2], 2'b00};
      mem_address    = 32'h0;
      mem_data_in    = 32'h0;
      mem_read_write = 1'b0;
      case (state)
         IDLE: begin
            if (grant_if || grant_d) begin
               if (req_err) begin
                  next_state = ACK;
               end else if (!req_we) begin
                  next_state = READ;
               end else if (req_size == SIZE_WORD) begin
                  next_state = WRITE;
               end else begin
                  next_state = RMW_RD;
               end
            end
         end
         READ: begin
            mem_address = aligned_addr;
            next_state  = ACK;
         end
         WRITE: begin
            mem_address    = aligned_addr;
            mem_data_in    = acc_wdata;
            mem_read_write = ~reset;
            next_state     = ACK;
         end
         RMW_RD: begin
            mem_address = aligned_addr;
            next_state  = RMW_WR;
         end
         RMW_WR: begin
            mem_address    = aligned_addr;
            mem_data_in    = merge;
            mem_read_write = ~reset;
            next_state     = ACK;
         end
         ACK: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register; reset aborts any access in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Access latches, merge buffer and the registered ack/err/rdata responses.
   always_ff @(posedge clock) begin
      if (reset) begin
         owner      <= OWN_IF;
         last_grant <= OWN_D;
         acc_addr   <= 32'h0;
         acc_size   <= 2'b00;
         acc_wdata  <= 32'h0;
         merge      <= 32'h0;
         if_ack     <= 1'b0;
         if_err     <= 1'b0;
         if_rdata   <= 32'h0;
         d_ack      <= 1'b0;
         d_err      <= 1'b0;
         d_rdata    <= 32'h0;
      end else begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_if || grant_d) begin
                  owner      <= grant_d;
                  last_grant <= grant_d;
                  acc_addr   <= req_addr;
                  acc_size   <= req_size;
                  acc_wdata  <= grant_d ? d_wdata : 32'h0;
                  if (req_err) begin
                     if (grant_d) begin
                        d_ack   <= 1'b1;
                        d_err   <= 1'b1;
                        d_rdata <= 32'h0;
                     end else begin
                        if_ack   <= 1'b1;
                        if_err   <= 1'b1;
                        if_rdata <= 32'h0;
                     end
                  end
               end
            end
            READ: begin
               if (owner == OWN_D) begin
                  d_ack   <= 1'b1;
                  d_err   <= 1'b0;
                  d_rdata <= load_data;
               end else begin
                  if_ack   <= 1'b1;
                  if_err   <= 1'b0;
                  if_rdata <= mem_data_out;
               end
            end
            WRITE, RMW_WR: begin
               d_ack <= 1'b1;
               d_err <= 1'b0;
            end
            RMW_RD: begin
               merge <= merge_word;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
